// File: rtl/pila_lifo.sv
// pila_lifo: LIFO stack with a combinational top-of-stack view, occupancy level,
// full/empty decode and sticky overflow/underflow error flags.
module pila_lifo #(
    parameter int WIDTH   = 10,
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               activar,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] nivel,
    output logic               overflow,
    output logic               underflow
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEVEL_W-1:0] LEVEL_ZERO = {LEVEL_W{1'b0}};
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = {{(LEVEL_W-1){1'b0}}, 1'b1};
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [LEVEL_W-1:0] sp_r;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic               overflow_r;
    logic               underflow_r;

    logic               empty_s;
    logic               full_s;
    logic               push_ok_s;
    logic               pop_ok_s;
    logic               push_err_s;
    logic               pop_err_s;
    logic [ADDR_W-1:0]  wr_idx_s;
    logic [ADDR_W-1:0]  rd_idx_s;
    logic [WIDTH-1:0]   dout_s;

    // Status decode from the pointer and qualification of the requested operation
    always_comb begin
        empty_s    = (sp_r == LEVEL_ZERO);
        full_s     = (sp_r == LEVEL_FULL);
        push_ok_s  = activar & push & ~full_s;
        pop_ok_s   = activar & ~push & ~empty_s;
        push_err_s = activar & push & full_s;
        pop_err_s  = activar & ~push & empty_s;
        // DEPTH is a power of two, so the low pointer bits wrap correctly when full
        wr_idx_s   = sp_r[ADDR_W-1:0];
        rd_idx_s   = sp_r[ADDR_W-1:0] - ADDR_ONE;
    end

    // Top-of-stack read, forced to zero when nothing is stacked
    always_comb begin
        dout_s = {WIDTH{1'b0}};
        if (empty_s) begin
            dout_s = {WIDTH{1'b0}};
        end else begin
            dout_s = mem_r[rd_idx_s];
        end
    end

    // Storage write; contents are meaningless below the pointer so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    // Stack pointer and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_r        <= LEVEL_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                sp_r <= sp_r + LEVEL_ONE;
            end else if (pop_ok_s) begin
                sp_r <= sp_r - LEVEL_ONE;
            end else begin
                sp_r <= sp_r;
            end
            if (push_err_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (pop_err_s) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    assign dout      = dout_s;
    assign empty     = empty_s;
    assign full      = full_s;
    assign nivel     = sp_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_pila_lifo.sv
// Self-checking bench for pila_lifo: directed boundary scenarios plus a random
// push/pop/hold run, all checked against a queue-based stack model.
module tb_pila_lifo;

    localparam int WIDTH   = 10;
    localparam int DEPTH   = 16;
    localparam int LEVEL_W = $clog2(DEPTH + 1);

    logic               clk;
    logic               reset;
    logic               activar;
    logic               push;
    logic [WIDTH-1:0]   din;
    logic [WIDTH-1:0]   dout;
    logic               empty;
    logic               full;
    logic [LEVEL_W-1:0] nivel;
    logic               overflow;
    logic               underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: a plain queue of words plus the two sticky flags
    logic [WIDTH-1:0] stk[$];
    logic             m_ov;
    logic             m_un;

    pila_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .activar   (activar),
        .push      (push),
        .din       (din),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .nivel     (nivel),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] m_top();
        if (stk.size() == 0) return 10'h000;
        return stk[$];
    endfunction

    function automatic logic [LEVEL_W-1:0] m_lvl();
        return LEVEL_W'(stk.size());
    endfunction

    // one operation per cycle: drive on the falling edge, update model at the rising edge
    task automatic apply(input logic act, input logic psh, input logic [WIDTH-1:0] d);
        @(negedge clk);
        activar = act;
        push    = psh;
        din     = d;
        @(posedge clk);
        if (act) begin
            if (psh) begin
                if (stk.size() == DEPTH) m_ov = 1'b1;
                else stk.push_back(d);
            end else begin
                if (stk.size() == 0) m_un = 1'b1;
                else void'(stk.pop_back());
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        activar = 1'b0;
        reset   = 1'b0;
        #2;
        reset   = 1'b1;
        stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 10'h2AA);
        apply(1'b1, 1'b1, 10'h155);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        n_checks++; if (nivel !== 5'd0) begin n_fail++; $display("FAIL reset_nivel: got %0d want 0", nivel); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (dout !== 10'h000) begin n_fail++; $display("FAIL reset_dout: got %h want 000", dout); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_unf: got %b want 0", underflow); end
        #1;
        reset = 1'b1;
    endtask

    task automatic test_lifo_order();
        logic [WIDTH-1:0] exp_w [3];
        exp_w[0] = 10'h3FF;
        exp_w[1] = 10'h00A;
        exp_w[2] = 10'h005;
        do_reset();
        apply(1'b1, 1'b1, 10'h005);
        apply(1'b1, 1'b1, 10'h00A);
        apply(1'b1, 1'b1, 10'h3FF);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (dout !== exp_w[i]) begin n_fail++; $display("FAIL lifo_dout[%0d]: got %h want %h", i, dout, exp_w[i]); end
            n_checks++; if (nivel !== LEVEL_W'(3 - i)) begin n_fail++; $display("FAIL lifo_nivel[%0d]: got %0d want %0d", i, nivel, 3 - i); end
            apply(1'b1, 1'b0, 10'h000);
        end
        n_checks++; if (nivel !== 5'd0) begin n_fail++; $display("FAIL lifo_end_nivel: got %0d want 0", nivel); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_end_empty: got %b want 1", empty); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL lifo_end_unf: got %b want 0", underflow); end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0", full); end
            end
            apply(1'b1, 1'b1, WIDTH'(i + 1));
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_pre: got %b want 0", overflow); end
        apply(1'b1, 1'b1, 10'h1AB);
        n_checks++; if (nivel !== 5'd16) begin n_fail++; $display("FAIL ovf_nivel: got %0d want 16", nivel); end
        n_checks++; if (dout !== 10'h010) begin n_fail++; $display("FAIL ovf_dout: got %h want 010", dout); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        apply(1'b1, 1'b0, 10'h000);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        n_checks++; if (nivel !== 5'd15) begin n_fail++; $display("FAIL ovf_pop_nivel: got %0d want 15", nivel); end
        n_checks++; if (dout !== 10'h00F) begin n_fail++; $display("FAIL ovf_pop_dout: got %h want 00F", dout); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_full: got %b want 0", full); end
    endtask

    task automatic test_empty_boundary();
        do_reset();
        apply(1'b1, 1'b0, 10'h000);
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b want 1", underflow); end
        n_checks++; if (nivel !== 5'd0) begin n_fail++; $display("FAIL unf_nivel: got %0d want 0", nivel); end
        n_checks++; if (dout !== 10'h000) begin n_fail++; $display("FAIL unf_dout: got %h want 000", dout); end
        apply(1'b1, 1'b1, 10'h123);
        n_checks++; if (dout !== 10'h123) begin n_fail++; $display("FAIL unf_push_dout: got %h want 123", dout); end
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b want 1", underflow); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL unf_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] held;
        do_reset();
        apply(1'b1, 1'b1, WIDTH'($urandom));
        apply(1'b1, 1'b1, WIDTH'($urandom));
        held = m_top();
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'($urandom), WIDTH'($urandom));
            n_checks++; if (nivel !== 5'd2) begin n_fail++; $display("FAIL hold_nivel[%0d]: got %0d want 2", i, nivel); end
            n_checks++; if (dout !== held) begin n_fail++; $display("FAIL hold_dout[%0d]: got %h want %h", i, dout, held); end
        end
    endtask

    task automatic test_call_return();
        do_reset();
        apply(1'b1, 1'b1, 10'h040);
        n_checks++; if (dout !== 10'h040) begin n_fail++; $display("FAIL call_dout: got %h want 040", dout); end
        apply(1'b1, 1'b0, 10'h000);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ret_empty: got %b want 1", empty); end
        apply(1'b1, 1'b1, 10'h040);
        // pop requested while reset is held low across the rising edge
        @(negedge clk);
        activar = 1'b1;
        push    = 1'b0;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        activar = 1'b0;
        reset   = 1'b1;
        stk.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_ret_empty: got %b want 1", empty); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_ret_unf: got %b want 0", underflow); end
        n_checks++; if (dout !== 10'h000) begin n_fail++; $display("FAIL rst_ret_dout: got %h want 000", dout); end
    endtask

    task automatic test_back_to_back_random();
        int push_pct;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            // phases biased towards filling, draining and mixing so both ends are hit
            push_pct = (i < 100) ? 80 : (i < 200) ? 15 : (i < 300) ? 90 : 40;
            n_checks++; if (dout !== m_top()) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h want %h", i, dout, m_top()); end
            n_checks++; if (nivel !== m_lvl()) begin n_fail++; $display("FAIL rnd_nivel[%0d]: got %0d want %0d", i, nivel, m_lvl()); end
            n_checks++; if (full !== (stk.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b want %b", i, full, stk.size() == DEPTH); end
            n_checks++; if (empty !== (stk.size() == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, empty, stk.size() == 0); end
            apply(($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < push_pct), WIDTH'($urandom));
        end
        n_checks++; if (overflow !== m_ov) begin n_fail++; $display("FAIL rnd_ovf: got %b want %b", overflow, m_ov); end
        n_checks++; if (underflow !== m_un) begin n_fail++; $display("FAIL rnd_unf: got %b want %b", underflow, m_un); end
    endtask

    initial begin
        reset   = 1'b0;
        activar = 1'b0;
        push    = 1'b0;
        din     = 10'h000;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_lifo_order();
        test_full_boundary();
        test_empty_boundary();
        test_hold();
        test_call_return();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pila_lifo.md
# pila_lifo

Hardware LIFO stack that serves as the responder for the control unit's stack commands. One instance holds subroutine return addresses (driven by `activarPilaSubR`/`pushPilaSubR`); a second instance holds data words (driven by `activarPilaDatos`/`pushPilaDatos`). The block executes one push or pop per enabled clock edge. It presents the current top-of-stack combinationally, so a `return` can load the PC in the same cycle it pops. It also reports occupancy, full/empty status, and sticky overflow/underflow errors.

## Interface
Parameters:
- `WIDTH`, 10: word width; equals the PC width for the subroutine stack instance.
- `DEPTH`, 16: number of entries; must be a power of two, ≥ 2.
- `LEVEL_W`, $clog2(DEPTH+1): width of `nivel`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `activar`  in  1  operation enable; when low the stack holds.
- `push`  in  1  with `activar`=1: 1 = push, 0 = pop.
- `din`  in  WIDTH  word to push.
- `dout`  out  WIDTH  current top-of-stack, combinational.
- `empty`  out  1  high when `nivel`==0.
- `full`  out  1  high when `nivel`==DEPTH.
- `nivel`  out  LEVEL_W  number of valid entries.
- `overflow`  out  1  sticky; a push was attempted while full.
- `underflow`  out  1  sticky; a pop was attempted while empty.

## Operation
- State:
  - `sp`: a LEVEL_W stack pointer, equal to `nivel`.
  - Storage array `mem[0..DEPTH-1]`, which is not reset.
  - `overflow` and `underflow` flags.
- Push (`activar`=1, `push`=1, not full): `mem[sp] <= din`, `sp <= sp+1`.
- Pop (`activar`=1, `push`=0, not empty): `sp <= sp-1`. The popped word is `dout` as seen before the edge; the caller samples it on that same edge.
- Push while full: storage and `sp` unchanged, incoming word discarded, `overflow <= 1`.
- Pop while empty: `sp` unchanged, `underflow <= 1`, `dout` reads 0.
- `activar`=0: no state change, regardless of `push` and `din`.
- `dout` = `empty` ? 0 : `mem[sp-1]`. It is purely combinational from registered state and never depends on `din` or the inputs in the current cycle.
- `empty` and `full` are decoded from `sp` only.
- `overflow` and `underflow` are cleared only by reset. A later legal operation does not clear them.
- Push and pop are mutually exclusive by encoding, so there is no simultaneous push/pop case.
- No pointer wrap-around: `sp` saturates at 0 and at DEPTH.

## Timing
- Reset (`reset`=0): asynchronous. Immediately forces `sp`=0, `overflow`=0, `underflow`=0. Resulting outputs: `nivel`=0, `empty`=1, `full`=0, `dout`=0. Storage contents are don't-care.
- Reset asserted mid-operation aborts the pending push or pop. No partial state survives.
- Release of `reset` is synchronous to the design; the first operation is accepted on the first rising edge after release.
- Push latency: the word pushed at edge N is visible on `dout` and counted in `nivel` right after edge N.
- Pop latency: `dout` shows the popped word during the cycle before edge N. After edge N, `dout` shows the next entry down, or 0 if the stack is now empty.
- `full` asserts immediately after the edge that performs the DEPTH-th push. `empty` asserts immediately after the edge that pops the last entry.
- Error flags assert on the edge of the illegal request and remain high until reset.
- Back-to-back operations, one per cycle, are supported without bubbles.

## Test plan
- Reset check: assert `reset`=0 mid-cycle with no clock edge. Expect immediately `nivel`=0, `empty`=1, `full`=0, `dout`=0, `overflow`=0, `underflow`=0.
- LIFO order: push 0x005, 0x00A, 0x3FF on consecutive cycles, then pop 3 times.
  - `dout` reads 0x3FF, 0x00A, 0x005 in the pop cycles.
  - `nivel` goes 3→2→1→0, ending with `empty`=1.
- Full boundary (DEPTH=16): push 16 words, where value = index+1.
  - `full`=1 after the 16th push.
  - A 17th push of 0x1AB leaves `nivel`=16 and `dout`=0x010, and sets `overflow`=1.
  - A subsequent pop returns 0x010 and `overflow` stays 1.
- Empty boundary: pop from empty. Expect `underflow`=1, `nivel`=0, `dout`=0. Then push 0x123; expect `dout`=0x123 and `underflow` still 1.
- Hold: with 2 entries stacked, drive `activar`=0 with random `push`/`din` for 10 cycles. Expect `nivel`=2 and `dout` unchanged throughout.
- Call/return sequence: push 0x040, immediately pop in the next cycle.
  - `dout`=0x040 during the pop cycle, which is what the PC loads.
  - `empty`=1 afterwards.
  - Repeat with `reset` pulsed low between the push and the pop: expect `empty`=1 and no underflow flag.
